ddr_rd_demux: RTL and testbench

//  Upstream feeder of the parameter-buffer loader. Accepts one DDR read-data beat stream and

---
 rtl/ddr_rd_demux_pkg.sv | 10 +
 rtl/ddr_rd_demux.sv | 143 ++++++++++++++
 tb/tb_ddr_rd_demux.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_demux_pkg.sv
// Shared definitions for the DDR read-data demultiplexer: beat type and the
// default transfer-counter width used by instantiating code.
package ddr_rd_demux_pkg;

  localparam int DDR_W          = 64;
  localparam int DDR_RD_TRANS_W = 8;

  typedef logic [DDR_W-1:0] ddr_beat_t;

endpackage

// File: rtl/ddr_rd_demux.sv
// ddr_rd_demux: splits one DDR read-beat stream into the loader's two lanes.
//   Single mode: every beat goes to ddr2.
//   Pair mode: beats alternate ddr1/ddr2 and leave together as one pair.
// Optional feature macro: DDR_RD_LAST_CHK_EN (checks ddr_rd_last against the
// expected final beat and raises sticky err_last on mismatch).
//
// Handshake: a beat is accepted when ddr_rd_valid & ddr_rd_ready are both high
// on a rising clock edge; ddr_rd_ready depends only on the FSM state, never on
// ddr_rd_valid. The output lanes have no backpressure: each *_valid is a
// single-cycle pulse and the data is meaningful only while its valid is high.
module ddr_rd_demux
  import ddr_rd_demux_pkg::*;
#(
  parameter int TRANS_W = DDR_RD_TRANS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  input  logic [TRANS_W-1:0] conf_trans_num,
  input  logic               conf_pair,
  input  ddr_beat_t          ddr_rd_data,
  input  logic               ddr_rd_valid,
  input  logic               ddr_rd_last,
  output logic               ddr_rd_ready,
  output ddr_beat_t          ddr1_data,
  output logic               ddr1_valid,
  output ddr_beat_t          ddr2_data,
  output logic               ddr2_valid,
  output logic               err_last
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [TRANS_W-1:0] trans_num_q;
  logic               pair_q;
  logic [TRANS_W-1:0] cnt_q;
  logic               half_q;
  ddr_beat_t          hold_q;

  logic accept;
  logic out_due;
  logic final_out;

  assign ddr_rd_ready = (state_q == RECV);
  assign done         = (state_q == IDLE);
  assign accept       = ddr_rd_valid & ddr_rd_ready;
  // An accepted beat produces an output unless it is the first half of a pair.
  assign out_due      = accept & (~pair_q | half_q);
  assign final_out    = (cnt_q == trans_num_q);

  // Next-state: start always (re)enters RECV; leave once the final output goes out.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RECV;
    end else if ((state_q == RECV) && out_due && final_out) begin
      state_d = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: conf latch, counter, pair hold register and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      trans_num_q <= '0;
      pair_q      <= 1'b0;
      cnt_q       <= '0;
      half_q      <= 1'b0;
      hold_q      <= '0;
      ddr1_data   <= '0;
      ddr1_valid  <= 1'b0;
      ddr2_data   <= '0;
      ddr2_valid  <= 1'b0;
    end else begin
      ddr1_valid <= 1'b0;
      ddr2_valid <= 1'b0;
      if (start) begin
        // Restart discards any partial pair and suppresses an output due now.
        trans_num_q <= conf_trans_num;
        pair_q      <= conf_pair;
        cnt_q       <= '0;
        half_q      <= 1'b0;
        hold_q      <= '0;
      end else if (accept) begin
        if (pair_q && !half_q) begin
          hold_q <= ddr_rd_data;
          half_q <= 1'b1;
        end else begin
          ddr2_data  <= ddr_rd_data;
          ddr2_valid <= 1'b1;
          if (pair_q) begin
            ddr1_data  <= hold_q;
            ddr1_valid <= 1'b1;
            half_q     <= 1'b0;
          end
          // Counter parks on the final value; start reloads it.
          if (!final_out) begin
            cnt_q <= cnt_q + TRANS_W'(1);
          end
        end
      end
    end
  end

`ifdef DDR_RD_LAST_CHK_EN
  logic err_q;
  logic exp_last;

  // The final expected beat is the one that produces the final output.
  assign exp_last = out_due & final_out;
  assign err_last = err_q;

  // Sticky last-flag mismatch; only start or reset clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (accept && (ddr_rd_last != exp_last)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = ddr_rd_last;
  assign err_last    = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rd_demux.sv
// Bench for ddr_rd_demux: transaction-level model (queues of pending beats,
// output counts) predicts every cycle's outputs; directed scenarios add
// literal expectations; randomized transfers follow.
module tb_ddr_rd_demux;
  import ddr_rd_demux_pkg::*;

  localparam int TW = DDR_RD_TRANS_W;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [TW-1:0] conf_trans_num = '0;
  logic          conf_pair = 1'b0;
  ddr_beat_t     ddr_rd_data = '0;
  logic          ddr_rd_valid = 1'b0;
  logic          ddr_rd_last = 1'b0;
  logic          done, ddr_rd_ready, ddr1_valid, ddr2_valid, err_last;
  ddr_beat_t     ddr1_data, ddr2_data;

  always #5 clk = ~clk;

  ddr_rd_demux #(.TRANS_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .conf_trans_num(conf_trans_num), .conf_pair(conf_pair),
    .ddr_rd_data(ddr_rd_data), .ddr_rd_valid(ddr_rd_valid),
    .ddr_rd_last(ddr_rd_last), .ddr_rd_ready(ddr_rd_ready),
    .ddr1_data(ddr1_data), .ddr1_valid(ddr1_valid),
    .ddr2_data(ddr2_data), .ddr2_valid(ddr2_valid),
    .err_last(err_last)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [DDR_W-1:0] exp_q[$];
  logic [DDR_W-1:0] exp1_q[$];
  ddr_beat_t obs1_q[$];
  ddr_beat_t obs2_q[$];

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input string name, input logic [DDR_W-1:0] act,
                            input logic [DDR_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transfer-level view: while busy, every offered beat is taken; beats are
  // grouped one (single) or two (pair) per output; after total outputs the
  // transfer is over. Expectations describe the cycle after each edge.
  bit        m_busy = 1'b0;
  bit        m_pair = 1'b0;
  int        m_total = 0;
  int        m_prod = 0;
  bit        m_err = 1'b0;
  ddr_beat_t m_pend[$];
  bit        e_v1 = 1'b0, e_v2 = 1'b0;
  ddr_beat_t e_d1 = '0, e_d2 = '0;

  always @(posedge clk) begin
    e_v1 = 1'b0;
    e_v2 = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_err  = 1'b0;
      m_pend.delete();
    end else if (start) begin
      m_busy  = 1'b1;
      m_pair  = conf_pair;
      m_total = int'(conf_trans_num) + 1;
      m_prod  = 0;
      m_err   = 1'b0;
      m_pend.delete();
    end else if (m_busy && ddr_rd_valid) begin
`ifdef DDR_RD_LAST_CHK_EN
      if (ddr_rd_last != ((m_prod == m_total - 1) && (!m_pair || m_pend.size() == 1)))
        m_err = 1'b1;
`endif
      m_pend.push_back(ddr_rd_data);
      if (m_pend.size() == (m_pair ? 2 : 1)) begin
        e_v2 = 1'b1;
        e_d2 = m_pend[m_pend.size()-1];
        if (m_pair) begin
          e_v1 = 1'b1;
          e_d1 = m_pend[0];
        end
        m_pend.delete();
        m_prod++;
        if (m_prod == m_total) m_busy = 1'b0;
      end
    end
  end

  // Compare process: every cycle, between active edges.
  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("ready", ddr_rd_ready, m_busy);
      check_bit("done", done, !m_busy);
      check_bit("ddr1_valid", ddr1_valid, e_v1);
      check_bit("ddr2_valid", ddr2_valid, e_v2);
      check_bit("err_last", err_last, m_err);
      if (e_v1 && ddr1_valid) check_data("ddr1_data", ddr1_data, e_d1);
      if (e_v2 && ddr2_valid) check_data("ddr2_data", ddr2_data, e_d2);
      if (ddr1_valid) obs1_q.push_back(ddr1_data);
      if (ddr2_valid) obs2_q.push_back(ddr2_data);
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ddr_rd_valid = 1'b0;
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_xfer(input int tn, input bit pair, input bit with_beat);
    start = 1'b1;
    conf_trans_num = TW'(tn);
    conf_pair = pair;
    if (with_beat) begin
      ddr_rd_valid = 1'b1;
      ddr_rd_data = {$urandom, $urandom};
      ddr_rd_last = 1'b1;
    end
    step();
    start = 1'b0;
    ddr_rd_valid = 1'b0;
    ddr_rd_last = 1'b0;
  endtask

  task automatic send_beat(input ddr_beat_t d, input bit last, input int gap);
    ddr_rd_valid = 1'b1;
    ddr_rd_data = d;
    ddr_rd_last = last;
    step();
    ddr_rd_valid = 1'b0;
    ddr_rd_last = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    check_bit("done_timeout", done, 1'b1);
    step();
    step();
  endtask

  task automatic clear_logs();
    obs1_q.delete();
    obs2_q.delete();
    exp_q.delete();
    exp1_q.delete();
  endtask

  task automatic compare_logs(input string name);
    check_int({name, "_n2"}, obs2_q.size(), exp_q.size());
    check_int({name, "_n1"}, obs1_q.size(), exp1_q.size());
    foreach (exp_q[i]) if (i < obs2_q.size()) check_data({name, "_d2"}, obs2_q[i], exp_q[i]);
    foreach (exp1_q[i]) if (i < obs1_q.size()) check_data({name, "_d1"}, obs1_q[i], exp1_q[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk_en = 1'b1;
    // Reset state.
    check_bit("rst_done", done, 1'b1);
    check_bit("rst_ready", ddr_rd_ready, 1'b0);
    check_bit("rst_v1", ddr1_valid, 1'b0);
    check_bit("rst_v2", ddr2_valid, 1'b0);
    check_data("rst_d1", ddr1_data, '0);
    check_data("rst_d2", ddr2_data, '0);
    check_bit("rst_err", err_last, 1'b0);

    // 1: single, 4 back-to-back beats.
    clear_logs();
    start_xfer(3, 1'b0, 1'b0);
    check_bit("t1_done_low", done, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(ddr_beat_t'(64'hD0 + i), i == 3, 0);
    // Final output was registered on the last edge: done already back.
    check_bit("t1_done_with_final", done, 1'b1);
    check_bit("t1_v2_final", ddr2_valid, 1'b1);
    wait_done();
    for (int i = 0; i < 4; i++) exp_q.push_back(64'hD0 + i);
    compare_logs("t1");

    // 2: pair, two pairs with 1-cycle gaps.
    clear_logs();
    start_xfer(1, 1'b1, 1'b0);
    send_beat(64'hA, 1'b0, 1);
    send_beat(64'hB, 1'b0, 1);
    send_beat(64'hC, 1'b0, 1);
    send_beat(64'hD, 1'b1, 1);
    wait_done();
    exp1_q = '{64'hA, 64'hC};
    exp_q  = '{64'hB, 64'hD};
    compare_logs("t2");

    // 3: pair restart after first beat; A discarded.
    clear_logs();
    start_xfer(0, 1'b1, 1'b0);
    send_beat(64'hA1, 1'b0, 0);
    start_xfer(0, 1'b1, 1'b0);
    send_beat(64'hE, 1'b0, 0);
    send_beat(64'hF, 1'b1, 0);
    wait_done();
    exp1_q = '{64'hE};
    exp_q  = '{64'hF};
    compare_logs("t3");

    // 4: beats held valid while idle are ignored.
    clear_logs();
    ddr_rd_valid = 1'b1;
    ddr_rd_data = 64'h1D1E;
    repeat (4) step();
    check_bit("t4_ready", ddr_rd_ready, 1'b0);
    ddr_rd_valid = 1'b0;
    compare_logs("t4");

    // 5: wrong last flag on beat 1 of a 3-beat single transfer.
    start_xfer(2, 1'b0, 1'b0);
    send_beat(64'h50, 1'b0, 0);
    send_beat(64'h51, 1'b1, 0);
`ifdef DDR_RD_LAST_CHK_EN
    check_bit("t5_err_set", err_last, 1'b1);
`else
    check_bit("t5_err_set", err_last, 1'b0);
`endif
    send_beat(64'h52, 1'b1, 0);
    wait_done();
    start_xfer(0, 1'b0, 1'b0);
    check_bit("t5_err_clr", err_last, 1'b0);
    send_beat(64'h53, 1'b1, 0);
    wait_done();

    // 6: reset mid pair transfer, then a fresh transfer.
    clear_logs();
    start_xfer(3, 1'b1, 1'b0);
    send_beat(64'h60, 1'b0, 0);
    send_beat(64'h61, 1'b0, 0);
    send_beat(64'h62, 1'b0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_bit("t6_done", done, 1'b1);
    check_bit("t6_ready", ddr_rd_ready, 1'b0);
    check_bit("t6_v1", ddr1_valid, 1'b0);
    check_bit("t6_v2", ddr2_valid, 1'b0);
    start_xfer(0, 1'b1, 1'b0);
    send_beat(64'h63, 1'b0, 0);
    send_beat(64'h64, 1'b1, 0);
    wait_done();
    exp1_q = '{64'h60, 64'h63};
    exp_q  = '{64'h61, 64'h64};
    compare_logs("t6");

    // Randomized transfers with gaps, restarts, start+beat collisions, bad last flags.
    for (int it = 0; it < 40; it++) begin
      int  tn    = $urandom_range(0, 4);
      bit  pair  = 1'($urandom_range(0, 1));
      int  beats = pair ? 2 * (tn + 1) : tn + 1;
      int  cut   = ($urandom_range(0, 5) == 0 && it != 39) ? $urandom_range(0, beats - 1) : beats;
      start_xfer(tn, pair, 1'($urandom_range(0, 3) == 0));
      for (int b = 0; b < cut; b++)
        send_beat({$urandom, $urandom}, (b == beats - 1) ^ ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 2));
      if (cut == beats) begin
        wait_done();
        ddr_rd_valid = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) step();
        ddr_rd_valid = 1'b0;
      end
    end
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: guarantees termination even if the DUT wedges.
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
